// File: rtl/sensor_frame_rx_pkg.sv
// sensor_frame_rx_pkg: shared frame constants and FSM state encoding (CHECK exists only with SENSOR_FRAME_CHKSUM_EN)
package sensor_frame_rx_pkg;
    localparam int PAYLOAD_LEN = 5;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam int TIMEOUT_DEFAULT = 50000;
`ifdef SENSOR_FRAME_CHKSUM_EN
    typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;
`else
    typedef enum logic [1:0] {HUNT, PAYLOAD} state_t;
`endif
endpackage

// File: rtl/sensor_frame_rx_timeout.sv
// frame_timeout: idle-cycle counter that pulses expired on the TIMEOUT_CYC-th consecutive idle cycle
module frame_timeout
    import sensor_frame_rx_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYC + 1);

    logic [W-1:0] cnt;

    assign expired = enable && !clear && cnt == W'(TIMEOUT_CYC - 1);

    // count idle cycles while enabled; restart on clear or once expired
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) cnt <= '0;
        else if (clear || expired || !enable) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/sensor_frame_rx.sv
// sensor_frame_rx: sync-delimited 5-byte frame receiver; optional checksum byte via SENSOR_FRAME_CHKSUM_EN
module sensor_frame_rx
    import sensor_frame_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
    parameter int         TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  rx_d,
    input  logic        rx_v,
    output logic [39:0] id_d,
    output logic        id_f,
    output logic        err_f,
    output logic [7:0]  err_cnt
);
    state_t      state, state_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [39:0] asm_q, asm_nxt;
    logic        done, abort, expired;
`ifdef SENSOR_FRAME_CHKSUM_EN
    logic [7:0]  sum_q, sum_nxt;
`endif

    frame_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clear   (rx_v || state == HUNT),
        .enable  (state != HUNT),
        .expired (expired)
    );

    // next-state, payload assembly and frame complete/abort decisions
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        asm_nxt   = asm_q;
        done      = 1'b0;
        abort     = 1'b0;
`ifdef SENSOR_FRAME_CHKSUM_EN
        sum_nxt   = sum_q;
`endif
        case (state)
            HUNT: begin
                // a sync byte landing while err_f is high is dropped
                if (rx_v && !err_f && rx_d == SYNC_BYTE) begin
                    state_nxt = PAYLOAD;
                    idx_nxt   = '0;
`ifdef SENSOR_FRAME_CHKSUM_EN
                    sum_nxt   = '0;
`endif
                end
            end
            PAYLOAD: begin
                if (rx_v) begin
                    asm_nxt = {asm_q[31:0], rx_d};
                    idx_nxt = idx + 3'd1;
`ifdef SENSOR_FRAME_CHKSUM_EN
                    sum_nxt = sum_q + rx_d;
                    if (idx == 3'(PAYLOAD_LEN - 1)) state_nxt = CHECK;
`else
                    if (idx == 3'(PAYLOAD_LEN - 1)) begin
                        state_nxt = HUNT;
                        done      = 1'b1;
                    end
`endif
                end else if (expired) begin
                    state_nxt = HUNT;
                    abort     = 1'b1;
                end
            end
`ifdef SENSOR_FRAME_CHKSUM_EN
            CHECK: begin
                if (rx_v) begin
                    state_nxt = HUNT;
                    done      = rx_d == sum_q;
                    abort     = rx_d != sum_q;
                end else if (expired) begin
                    state_nxt = HUNT;
                    abort     = 1'b1;
                end
            end
`endif
            default: state_nxt = HUNT;
        endcase
    end

    // state, assembly and registered output pulses/counters
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= HUNT;
            idx     <= '0;
            asm_q   <= '0;
            id_d    <= '0;
            id_f    <= 1'b0;
            err_f   <= 1'b0;
            err_cnt <= '0;
`ifdef SENSOR_FRAME_CHKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            asm_q <= asm_nxt;
            id_f  <= done;
            err_f <= abort;
            if (done) id_d <= asm_nxt;
            if (abort && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`ifdef SENSOR_FRAME_CHKSUM_EN
            sum_q <= sum_nxt;
`endif
        end
    end
endmodule
